// File: rtl/l1_cache_controller.sv
// L1 data cache control FSM plus CPU word-select muxes.
// Define L1_CACHE_CTRL_PERF_CNT_EN to add hit/miss counters.
module l1_cache_controller #(
   parameter int MEM_LATENCY = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic cache_cs,
   input  logic cache_we,
   input  logic cache_hit,
   input  logic cache_dirty,
   output logic sram_cs,
   output logic sram_we,
   output logic stall,
   output logic mem_cs,
   output logic mem_we,
   output logic mem_wb
`ifdef L1_CACHE_CTRL_PERF_CNT_EN
   ,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
`endif
);

   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE,
      REFILL
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          cnt_last;
   logic          miss;

   assign cnt_last = (cnt == CW'(MEM_LATENCY - 1));
   assign miss     = (state == IDLE) & cache_cs & ~cache_hit;

   // state and transfer-cycle counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // next state, counter and outputs; all outputs held low during reset
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      sram_cs  = 1'b0;
      sram_we  = 1'b0;
      stall    = 1'b0;
      mem_cs   = 1'b0;
      mem_we   = 1'b0;
      mem_wb   = 1'b0;
      unique case (state)
         IDLE: begin
            sram_cs = cache_cs;
            if (cache_cs & cache_hit) begin
               sram_we = cache_we;
            end else if (cache_cs) begin
               stall  = 1'b1;
               cnt_nx = '0;
               state_nx = cache_dirty ? WRITEBACK : ALLOCATE;
            end
         end
         WRITEBACK: begin
            mem_cs = 1'b1;
            mem_we = 1'b1;
            mem_wb = 1'b1;
            stall  = 1'b1;
            if (cnt_last) begin
               cnt_nx   = '0;
               state_nx = ALLOCATE;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         ALLOCATE: begin
            mem_cs = 1'b1;
            stall  = 1'b1;
            if (cnt_last) begin
               cnt_nx   = '0;
               state_nx = REFILL;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         REFILL: begin
            sram_cs  = 1'b1;
            sram_we  = 1'b1;
            stall    = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (!rst) begin
         sram_cs = 1'b0;
         sram_we = 1'b0;
         stall   = 1'b0;
         mem_cs  = 1'b0;
         mem_we  = 1'b0;
         mem_wb  = 1'b0;
      end
   end

`ifdef L1_CACHE_CTRL_PERF_CNT_EN
   logic refill_done;

   // count hits (not the post-refill completion) and miss detections
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt     <= '0;
         miss_cnt    <= '0;
         refill_done <= 1'b0;
      end else begin
         refill_done <= (state == REFILL);
         if ((state == IDLE) & cache_cs & cache_hit & ~refill_done)
            hit_cnt <= hit_cnt + 32'd1;
         if (miss)
            miss_cnt <= miss_cnt + 32'd1;
      end
   end
`else
   logic unused_miss;
   assign unused_miss = miss;
`endif

endmodule

// 8-to-1 word select; sel=k picks data_(k+1)
module Multiplexer8Way (
   input  logic [31:0] data_1,
   input  logic [31:0] data_2,
   input  logic [31:0] data_3,
   input  logic [31:0] data_4,
   input  logic [31:0] data_5,
   input  logic [31:0] data_6,
   input  logic [31:0] data_7,
   input  logic [31:0] data_8,
   input  logic [2:0]  sel,
   output logic [31:0] data_o
);
   // word select
   always_comb begin
      data_o = data_1;
      unique case (sel)
         3'd0: data_o = data_1;
         3'd1: data_o = data_2;
         3'd2: data_o = data_3;
         3'd3: data_o = data_4;
         3'd4: data_o = data_5;
         3'd5: data_o = data_6;
         3'd6: data_o = data_7;
         3'd7: data_o = data_8;
         default: data_o = data_1;
      endcase
   end
endmodule

// 4-to-1 word select; sel=k picks data_(k+1)
module Multiplexer4Way (
   input  logic [31:0] data_1,
   input  logic [31:0] data_2,
   input  logic [31:0] data_3,
   input  logic [31:0] data_4,
   input  logic [1:0]  sel,
   output logic [31:0] data_o
);
   // word select
   always_comb begin
      data_o = data_1;
      unique case (sel)
         2'd0: data_o = data_1;
         2'd1: data_o = data_2;
         2'd2: data_o = data_3;
         2'd3: data_o = data_4;
         default: data_o = data_1;
      endcase
   end
endmodule

// File: tb/tb_l1_cache_controller.sv
// Directed bench for l1_cache_controller and word-select muxes.
// Outputs packed as {sram_cs,sram_we,stall,mem_cs,mem_we,mem_wb}.
module tb_l1_cache_controller;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic cache_cs = 1'b0;
   logic cache_we = 1'b0;
   logic cache_hit = 1'b0;
   logic cache_dirty = 1'b0;
   logic sram_cs, sram_we, stall, mem_cs, mem_we, mem_wb;

   logic [31:0] d8_o, d4_o;
   logic [2:0]  sel8 = 3'd0;
   logic [1:0]  sel4 = 2'd0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   l1_cache_controller #(.MEM_LATENCY(10)) dut (
      .clk(clk),
      .rst(rst),
      .cache_cs(cache_cs),
      .cache_we(cache_we),
      .cache_hit(cache_hit),
      .cache_dirty(cache_dirty),
      .sram_cs(sram_cs),
      .sram_we(sram_we),
      .stall(stall),
      .mem_cs(mem_cs),
      .mem_we(mem_we),
      .mem_wb(mem_wb)
   );

   Multiplexer8Way m8 (
      .data_1(32'd1), .data_2(32'd2), .data_3(32'd3), .data_4(32'd4),
      .data_5(32'd5), .data_6(32'd6), .data_7(32'd7), .data_8(32'd8),
      .sel(sel8), .data_o(d8_o)
   );

   Multiplexer4Way m4 (
      .data_1(32'hA1), .data_2(32'hB2), .data_3(32'hC3), .data_4(32'hD4),
      .sel(sel4), .data_o(d4_o)
   );

   function automatic logic [31:0] outs();
      return {26'd0, sram_cs, sram_we, stall, mem_cs, mem_we, mem_wb};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic edge_drv();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset with a pending miss on the inputs
      cache_cs = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", outs(), 32'h00);
      rst = 1'b1;
      #1;
      chk("release_stall", outs(), 32'h28);
      cache_cs = 1'b0;

      // read hit
      edge_drv();
      cache_cs = 1'b1; cache_we = 1'b0; cache_hit = 1'b1;
      @(negedge clk);
      chk("read_hit", outs(), 32'h20);

      // write hit, one cycle
      edge_drv();
      cache_we = 1'b1;
      @(negedge clk);
      chk("write_hit", outs(), 32'h30);
      edge_drv();
      cache_cs = 1'b0; cache_we = 1'b0;
      @(negedge clk);
      chk("write_hit_end", outs(), 32'h00);

      // clean read miss
      edge_drv();
      cache_cs = 1'b1; cache_hit = 1'b0; cache_dirty = 1'b0;
      @(negedge clk);
      chk("clean_miss_cyc0", outs(), 32'h28);
      for (int i = 1; i <= 10; i++) begin
         edge_drv();
         @(negedge clk);
         chk($sformatf("clean_alloc_%0d", i), outs(), 32'h0C);
      end
      edge_drv();
      @(negedge clk);
      chk("clean_refill", outs(), 32'h38);
      edge_drv();
      cache_hit = 1'b1;
      @(negedge clk);
      chk("clean_done_c12", outs(), 32'h20);
      edge_drv();
      cache_cs = 1'b0;

      // dirty write miss
      edge_drv();
      cache_cs = 1'b1; cache_we = 1'b1;
      cache_hit = 1'b0; cache_dirty = 1'b1;
      @(negedge clk);
      chk("dirty_miss_cyc0", outs(), 32'h28);
      for (int i = 1; i <= 10; i++) begin
         edge_drv();
         @(negedge clk);
         chk($sformatf("dirty_wb_%0d", i), outs(), 32'h0F);
      end
      for (int i = 11; i <= 20; i++) begin
         edge_drv();
         @(negedge clk);
         chk($sformatf("dirty_alloc_%0d", i), outs(), 32'h0C);
      end
      edge_drv();
      @(negedge clk);
      chk("dirty_refill_c21", outs(), 32'h38);
      edge_drv();
      cache_hit = 1'b1; cache_dirty = 1'b0;
      @(negedge clk);
      chk("dirty_write_hit_c22", outs(), 32'h30);
      edge_drv();
      cache_cs = 1'b0; cache_we = 1'b0;

      // clean miss with cache_cs dropped during allocate
      edge_drv();
      cache_cs = 1'b1; cache_hit = 1'b0;
      @(negedge clk);
      chk("drop_miss_cyc0", outs(), 32'h28);
      for (int i = 1; i <= 10; i++) begin
         edge_drv();
         if (i == 3) cache_cs = 1'b0;
         @(negedge clk);
         chk($sformatf("drop_alloc_%0d", i), outs(), 32'h0C);
      end
      edge_drv();
      @(negedge clk);
      chk("drop_refill", outs(), 32'h38);
      edge_drv();
      @(negedge clk);
      chk("drop_idle", outs(), 32'h00);

      // reset mid-transfer aborts to idle
      edge_drv();
      cache_cs = 1'b1; cache_hit = 1'b0;
      repeat (4) edge_drv();
      cache_cs = 1'b0;
      @(negedge clk);
      chk("abort_pre", outs(), 32'h0C);
      rst = 1'b0;
      #1;
      chk("abort_rst", outs(), 32'h00);
      edge_drv();
      rst = 1'b1;
      @(negedge clk);
      chk("abort_idle", outs(), 32'h00);
      edge_drv();
      cache_cs = 1'b1; cache_hit = 1'b1;
      @(negedge clk);
      chk("abort_then_hit", outs(), 32'h20);
      edge_drv();
      cache_cs = 1'b0;

      // word-select muxes
      sel8 = 3'd5; #1; chk("mux8_sel5", d8_o, 32'd6);
      sel8 = 3'd0; #1; chk("mux8_sel0", d8_o, 32'd1);
      sel8 = 3'd7; #1; chk("mux8_sel7", d8_o, 32'd8);
      sel4 = 2'd2; #1; chk("mux4_sel2", d4_o, 32'hC3);
      sel4 = 2'd0; #1; chk("mux4_sel0", d4_o, 32'hA1);
      sel4 = 2'd3; #1; chk("mux4_sel3", d4_o, 32'hD4);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
